control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit that replaces the hand-stepped control sequences of our datapath benches. It generates the datapath control strobes (fetch, decode, execute) from the current instruction register, with no external stimulus required. Successor to fixed two-step ldi/jal sequences: parametrised memory wait states, a retired-instruction counter, ALU/MUL/JR/NOP/HALT classes, illegal-opcode flagging and a stop/idle handshake. Sits beside `datapath`; its outputs connect one-for-one to the datapath control ports.

## Interface
- MEM_WAIT, 0: extra cycles `read`/`mdr_enable` are held in T1 (0..15).
- CNT_W, 16: width of `instr_count`.
- clk  in  1  clock, all state changes on rising edge
- clr  in  1  reset, asynchronous, active-high
- ir  in  32  instruction register contents; opcode = ir[31:27]
- stop  in  1  request to park in IDLE after the current instruction
- pc_out, zlo_out, zhi_out, mdr_out, mar_enable, z_enable, lo_enable, hi_enable, pc_enable, mdr_enable, read, ir_enable, y_enable, pc_increment, r15_enable, c_sign_extended_out, r_in, r_out, gra, grb, grc, ba_out  out  1 each  datapath control strobes
- alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 mul
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal_op  out  1  one-cycle pulse in T3 on an unknown opcode
- halted  out  1  high while in HALT
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- States: RST, IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. All strobes are Moore outputs decoded from the registered state (plus the latched opcode in T3–T6). Strobes not listed for a state are 0.
- Fetch: T0 drives pc_out, mar_enable, pc_increment, z_enable. T1 drives read and mdr_enable for 1+MEM_WAIT cycles (wait counter); zlo_out and pc_enable are driven only in the last T1 cycle. T2 drives mdr_out and ir_enable.
- T3 decode: samples opcode from `ir` into an opcode register; execute-state outputs use that register.
- Execute steps:
  - ALU (00011 add, 00100 sub, 00101 and, 00110 or): T3 grb+r_out+y_enable; T4 grc+r_out+alu_op+z_enable; T5 zlo_out+gra+r_in.
  - LDI 01000: T3 grb+ba_out+y_enable; T4 c_sign_extended_out+z_enable, alu_op=000; T5 zlo_out+gra+r_in.
  - MUL 01111: T3 gra+r_out+y_enable; T4 grb+r_out+z_enable, alu_op=100; T5 zlo_out+lo_enable; T6 zhi_out+hi_enable.
  - JAL 10011: T3 pc_out+r15_enable; T4 gra+r_out+pc_enable.
  - JR 10100: T3 gra+r_out+pc_enable.
  - NOP 11010: T3 empty.
  - HALT 11011: T3 empty, then HALT.
  - Any other opcode: illegal_op=1 in T3, then handled as NOP.
- The final execute state asserts instr_done, and instr_count increments on its closing edge. HALT counts as retired.
- After the final state: stop=1 → IDLE, otherwise → T0. IDLE → T0 on the first edge with stop=0.
- HALT: halted=1, all strobes 0, exits only via clr.

## Timing
- clr asserted: state RST immediately. All outputs 0, alu_op=000, instr_count=0, wait counter=0, opcode register=0.
- First rising edge with clr low: RST → T0.
- Latency from T0 to the final state: ALU/LDI 6+MEM_WAIT cycles; MUL 7+MEM_WAIT; JAL 5+MEM_WAIT; JR/NOP/HALT 4+MEM_WAIT.
- stop is sampled only on the edge leaving the final state. Assertion mid-instruction does not abort it.
- clr mid-instruction aborts immediately, with no instr_done and no count increment.
- instr_count wraps from 2^CNT_W−1 to 0.

## Test plan
- MEM_WAIT=0, ir=0x40880000 (LDI, ra=1, rb=1), stop=0: T0..T5 in 6 cycles; T5 has zlo_out=gra=r_in=1; instr_done pulses once; instr_count 0→1.
- MEM_WAIT=2, ADD opcode: read/mdr_enable high exactly 3 consecutive cycles; pc_enable high only in the 3rd; instruction completes in 8 cycles with alu_op=000 in T4.
- JAL then JR: JAL T3 has pc_out=r15_enable=1, T4 has pc_enable=gra=r_out=1. JR finishes in 4 cycles.
- MUL: T5 lo_enable=1 and T6 hi_enable=1; alu_op=100 in T4; instr_done only in T6.
- opcode 11111 then HALT: illegal_op pulses in T3 and the sequence returns to T0. HALT sets halted=1, and the state holds for 20 cycles with all strobes 0 and instr_count=2.
- stop=1 asserted in T1: the instruction completes, then the state enters IDLE. Deasserting stop gives T0 on the next edge. clr pulsed in T4 zeroes all outputs and the count asynchronously.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control sequencer for the datapath.
// Strobes are registered copies of the decode of the next state, so they line up with the state register.
module control_sequencer #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      ir,
    input  logic             stop,
    output logic             pc_out,
    output logic             zlo_out,
    output logic             zhi_out,
    output logic             mdr_out,
    output logic             mar_enable,
    output logic             z_enable,
    output logic             lo_enable,
    output logic             hi_enable,
    output logic             pc_enable,
    output logic             mdr_enable,
    output logic             read,
    output logic             ir_enable,
    output logic             y_enable,
    output logic             pc_increment,
    output logic             r15_enable,
    output logic             c_sign_extended_out,
    output logic             r_in,
    output logic             r_out,
    output logic             gra,
    output logic             grb,
    output logic             grc,
    output logic             ba_out,
    output logic [2:0]       alu_op,
    output logic             instr_done,
    output logic             illegal_op,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_RST, S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_e;

    typedef struct packed {
        logic pc_out, zlo_out, zhi_out, mdr_out, mar_enable, z_enable;
        logic lo_enable, hi_enable, pc_enable, mdr_enable, read, ir_enable;
        logic y_enable, pc_increment, r15_enable, c_sign_extended_out;
        logic r_in, r_out, gra, grb, grc, ba_out;
        logic [2:0] alu_op;
        logic instr_done, illegal_op, halted;
    } ctrl_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_LDI  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_JAL  = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_e            state_r, state_next_s;
    logic [4:0]        opcode_r, opcode_next_s;
    logic [3:0]        wait_r, wait_next_s;
    ctrl_t             ctrl_r;
    logic [CNT_W-1:0]  count_r;
    logic              unused_ir_s;

    assign unused_ir_s = ^ir[26:0];

    function automatic state_e last_state(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI: last_state = S_T5;
            OP_MUL:                                last_state = S_T6;
            OP_JAL:                                last_state = S_T4;
            default:                               last_state = S_T3;
        endcase
    endfunction

    function automatic ctrl_t decode(input state_e st, input logic [4:0] op, input logic [3:0] wcnt);
        ctrl_t c;
        c = '0;
        case (st)
            S_T0: begin
                c.pc_out = 1'b1; c.mar_enable = 1'b1; c.pc_increment = 1'b1; c.z_enable = 1'b1;
            end
            S_T1: begin
                c.read = 1'b1; c.mdr_enable = 1'b1;
                // PC update waits for the last memory wait cycle
                if (wcnt == WAIT_LAST) begin
                    c.zlo_out = 1'b1; c.pc_enable = 1'b1;
                end else begin
                    c.zlo_out = 1'b0; c.pc_enable = 1'b0;
                end
            end
            S_T2: begin
                c.mdr_out = 1'b1; c.ir_enable = 1'b1;
            end
            S_T3: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin c.grb = 1'b1; c.r_out = 1'b1; c.y_enable = 1'b1; end
                    OP_LDI:  begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_enable = 1'b1; end
                    OP_MUL:  begin c.gra = 1'b1; c.r_out = 1'b1; c.y_enable = 1'b1; end
                    OP_JAL:  begin c.pc_out = 1'b1; c.r15_enable = 1'b1; end
                    OP_JR:   begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_enable = 1'b1; end
                    OP_NOP, OP_HALT: c.illegal_op = 1'b0;
                    default: c.illegal_op = 1'b1;
                endcase
            end
            S_T4: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        c.grc = 1'b1; c.r_out = 1'b1; c.z_enable = 1'b1;
                        c.alu_op = 3'(op - OP_ADD);
                    end
                    OP_LDI:  begin c.c_sign_extended_out = 1'b1; c.z_enable = 1'b1; c.alu_op = 3'b000; end
                    OP_MUL:  begin c.grb = 1'b1; c.r_out = 1'b1; c.z_enable = 1'b1; c.alu_op = 3'b100; end
                    OP_JAL:  begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_enable = 1'b1; end
                    default: c.alu_op = 3'b000;
                endcase
            end
            S_T5: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI: begin c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                    OP_MUL:  begin c.zlo_out = 1'b1; c.lo_enable = 1'b1; end
                    default: c.zlo_out = 1'b0;
                endcase
            end
            S_T6: begin
                c.zhi_out = 1'b1; c.hi_enable = 1'b1;
            end
            S_HALT:  c.halted = 1'b1;
            default: c.halted = 1'b0;
        endcase
        c.instr_done = (st == last_state(op));
        return c;
    endfunction

    // Next-state, opcode capture and memory wait counter
    always_comb begin
        state_next_s  = state_r;
        opcode_next_s = opcode_r;
        wait_next_s   = wait_r;
        case (state_r)
            S_RST:  state_next_s = S_T0;
            S_IDLE: begin
                if (!stop) state_next_s = S_T0;
                else       state_next_s = S_IDLE;
            end
            S_T0: begin
                state_next_s = S_T1;
                wait_next_s  = 4'd0;
            end
            S_T1: begin
                if (wait_r == WAIT_LAST) begin
                    state_next_s = S_T2;
                    wait_next_s  = 4'd0;
                end else begin
                    wait_next_s  = wait_r + 4'd1;
                end
            end
            S_T2: begin
                state_next_s  = S_T3;
                opcode_next_s = ir[31:27];
            end
            S_T3, S_T4, S_T5, S_T6: begin
                if (state_r == last_state(opcode_r)) begin
                    if (opcode_r == OP_HALT) state_next_s = S_HALT;
                    else if (stop)           state_next_s = S_IDLE;
                    else                     state_next_s = S_T0;
                end else begin
                    case (state_r)
                        S_T3:    state_next_s = S_T4;
                        S_T4:    state_next_s = S_T5;
                        S_T5:    state_next_s = S_T6;
                        default: state_next_s = S_RST;
                    endcase
                end
            end
            S_HALT:  state_next_s = S_HALT;
            default: state_next_s = S_RST;
        endcase
    end

    // State, opcode, wait counter, registered strobes and retired-instruction count
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r  <= S_RST;
            opcode_r <= 5'd0;
            wait_r   <= 4'd0;
            ctrl_r   <= '0;
            count_r  <= '0;
        end else begin
            state_r  <= state_next_s;
            opcode_r <= opcode_next_s;
            wait_r   <= wait_next_s;
            ctrl_r   <= decode(state_next_s, opcode_next_s, wait_next_s);
            if (state_r == last_state(opcode_r)) count_r <= count_r + CNT_W'(1);
            else                                 count_r <= count_r;
        end
    end

    assign pc_out              = ctrl_r.pc_out;
    assign zlo_out             = ctrl_r.zlo_out;
    assign zhi_out             = ctrl_r.zhi_out;
    assign mdr_out             = ctrl_r.mdr_out;
    assign mar_enable          = ctrl_r.mar_enable;
    assign z_enable            = ctrl_r.z_enable;
    assign lo_enable           = ctrl_r.lo_enable;
    assign hi_enable           = ctrl_r.hi_enable;
    assign pc_enable           = ctrl_r.pc_enable;
    assign mdr_enable          = ctrl_r.mdr_enable;
    assign read                = ctrl_r.read;
    assign ir_enable           = ctrl_r.ir_enable;
    assign y_enable            = ctrl_r.y_enable;
    assign pc_increment        = ctrl_r.pc_increment;
    assign r15_enable          = ctrl_r.r15_enable;
    assign c_sign_extended_out = ctrl_r.c_sign_extended_out;
    assign r_in                = ctrl_r.r_in;
    assign r_out               = ctrl_r.r_out;
    assign gra                 = ctrl_r.gra;
    assign grb                 = ctrl_r.grb;
    assign grc                 = ctrl_r.grc;
    assign ba_out              = ctrl_r.ba_out;
    assign alu_op              = ctrl_r.alu_op;
    assign instr_done          = ctrl_r.instr_done;
    assign illegal_op          = ctrl_r.illegal_op;
    assign halted              = ctrl_r.halted;
    assign instr_count         = count_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a cycle-indexed instruction model predicts every strobe.
module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr_a, clr_b, stop_a, stop_b;
    logic [31:0] ir_a, ir_b;
    logic [21:0] sa, sb;
    logic [2:0]  alu_a, alu_b;
    logic        done_a, done_b, ill_a, ill_b, halt_a, halt_b;
    logic [15:0] cnt_a;
    logic [2:0]  cnt_b;
    logic [27:0] obs_a, obs_b;

    assign obs_a = {halt_a, ill_a, done_a, alu_a, sa};
    assign obs_b = {halt_b, ill_b, done_b, alu_b, sb};

    int total = 0;
    int bad = 0;
    int exp_cnt_a = 0;
    int exp_cnt_b = 0;

    localparam logic [27:0] PC_OUT  = 28'd1 << 0;
    localparam logic [27:0] ZLO     = 28'd1 << 1;
    localparam logic [27:0] ZHI     = 28'd1 << 2;
    localparam logic [27:0] MDR_OUT = 28'd1 << 3;
    localparam logic [27:0] MAR_EN  = 28'd1 << 4;
    localparam logic [27:0] Z_EN    = 28'd1 << 5;
    localparam logic [27:0] LO_EN   = 28'd1 << 6;
    localparam logic [27:0] HI_EN   = 28'd1 << 7;
    localparam logic [27:0] PC_EN   = 28'd1 << 8;
    localparam logic [27:0] MDR_EN  = 28'd1 << 9;
    localparam logic [27:0] READ    = 28'd1 << 10;
    localparam logic [27:0] IR_EN   = 28'd1 << 11;
    localparam logic [27:0] Y_EN    = 28'd1 << 12;
    localparam logic [27:0] PC_INC  = 28'd1 << 13;
    localparam logic [27:0] R15_EN  = 28'd1 << 14;
    localparam logic [27:0] CSE     = 28'd1 << 15;
    localparam logic [27:0] R_IN    = 28'd1 << 16;
    localparam logic [27:0] R_OUT   = 28'd1 << 17;
    localparam logic [27:0] GRA     = 28'd1 << 18;
    localparam logic [27:0] GRB     = 28'd1 << 19;
    localparam logic [27:0] GRC     = 28'd1 << 20;
    localparam logic [27:0] BA_OUT  = 28'd1 << 21;
    localparam logic [27:0] DONE    = 28'd1 << 25;
    localparam logic [27:0] ILLEGAL = 28'd1 << 26;
    localparam logic [27:0] HALTED  = 28'd1 << 27;

    logic [4:0] legal_ops [0:8] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd15, 5'd19, 5'd20, 5'd26};

    control_sequencer #(.MEM_WAIT(0), .CNT_W(16)) dut_a (
        .clk(clk), .clr(clr_a), .ir(ir_a), .stop(stop_a),
        .pc_out(sa[0]), .zlo_out(sa[1]), .zhi_out(sa[2]), .mdr_out(sa[3]), .mar_enable(sa[4]),
        .z_enable(sa[5]), .lo_enable(sa[6]), .hi_enable(sa[7]), .pc_enable(sa[8]), .mdr_enable(sa[9]),
        .read(sa[10]), .ir_enable(sa[11]), .y_enable(sa[12]), .pc_increment(sa[13]), .r15_enable(sa[14]),
        .c_sign_extended_out(sa[15]), .r_in(sa[16]), .r_out(sa[17]), .gra(sa[18]), .grb(sa[19]),
        .grc(sa[20]), .ba_out(sa[21]), .alu_op(alu_a), .instr_done(done_a), .illegal_op(ill_a),
        .halted(halt_a), .instr_count(cnt_a)
    );

    control_sequencer #(.MEM_WAIT(2), .CNT_W(3)) dut_b (
        .clk(clk), .clr(clr_b), .ir(ir_b), .stop(stop_b),
        .pc_out(sb[0]), .zlo_out(sb[1]), .zhi_out(sb[2]), .mdr_out(sb[3]), .mar_enable(sb[4]),
        .z_enable(sb[5]), .lo_enable(sb[6]), .hi_enable(sb[7]), .pc_enable(sb[8]), .mdr_enable(sb[9]),
        .read(sb[10]), .ir_enable(sb[11]), .y_enable(sb[12]), .pc_increment(sb[13]), .r15_enable(sb[14]),
        .c_sign_extended_out(sb[15]), .r_in(sb[16]), .r_out(sb[17]), .gra(sb[18]), .grb(sb[19]),
        .grc(sb[20]), .ba_out(sb[21]), .alu_op(alu_b), .instr_done(done_b), .illegal_op(ill_b),
        .halted(halt_b), .instr_count(cnt_b)
    );

    // Number of execute cycles an opcode takes after the three fetch steps.
    function automatic int n_steps(input logic [4:0] op);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd8: return 3;
            5'd15:                        return 4;
            5'd19:                        return 2;
            default:                      return 1;
        endcase
    endfunction

    function automatic int ilen(input logic [4:0] op, input int mw);
        return 3 + mw + n_steps(op);
    endfunction

    // Expected strobe word for cycle k counted from T0 of an instruction.
    function automatic logic [27:0] exp_vec(input logic [4:0] op, input int mw, input int k);
        logic [27:0] v;
        int e;
        v = '0;
        e = k - (3 + mw);
        if (k == 0) v = PC_OUT | MAR_EN | PC_INC | Z_EN;
        else if (k <= 1 + mw) begin
            v = READ | MDR_EN;
            if (k == 1 + mw) v = v | ZLO | PC_EN;
        end else if (k == 2 + mw) v = MDR_OUT | IR_EN;
        else begin
            case (op)
                5'd3, 5'd4, 5'd5, 5'd6: begin
                    if (e == 0) v = GRB | R_OUT | Y_EN;
                    if (e == 1) v = GRC | R_OUT | Z_EN | ((28'(op) - 28'd3) << 22);
                    if (e == 2) v = ZLO | GRA | R_IN;
                end
                5'd8: begin
                    if (e == 0) v = GRB | BA_OUT | Y_EN;
                    if (e == 1) v = CSE | Z_EN;
                    if (e == 2) v = ZLO | GRA | R_IN;
                end
                5'd15: begin
                    if (e == 0) v = GRA | R_OUT | Y_EN;
                    if (e == 1) v = GRB | R_OUT | Z_EN | (28'd4 << 22);
                    if (e == 2) v = ZLO | LO_EN;
                    if (e == 3) v = ZHI | HI_EN;
                end
                5'd19: begin
                    if (e == 0) v = PC_OUT | R15_EN;
                    if (e == 1) v = GRA | R_OUT | PC_EN;
                end
                5'd20:          v = GRA | R_OUT | PC_EN;
                5'd26, 5'd27:   v = '0;
                default:        v = ILLEGAL;
            endcase
            if (e == n_steps(op) - 1) v = v | DONE;
        end
        return v;
    endfunction

    function automatic logic [4:0] rand_op();
        logic [4:0] op;
        if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
        else                          op = legal_ops[$urandom_range(0, 8)];
        if (op == 5'd27) op = 5'd26;
        return op;
    endfunction

    task automatic test_reset();
        clr_a = 1'b1; clr_b = 1'b1; stop_a = 1'b0; stop_b = 1'b0;
        ir_a = 32'd0; ir_b = 32'd0;
        @(negedge clk); @(negedge clk);
        total++; if (obs_a !== 28'd0) begin bad++; $display("FAIL reset_a_strobes got=%h exp=0", obs_a); end
        total++; if (cnt_a !== 16'd0) begin bad++; $display("FAIL reset_a_count got=%0d exp=0", cnt_a); end
        total++; if (obs_b !== 28'd0) begin bad++; $display("FAIL reset_b_strobes got=%h exp=0", obs_b); end
        total++; if (cnt_b !== 3'd0) begin bad++; $display("FAIL reset_b_count got=%0d exp=0", cnt_b); end
    endtask

    task automatic test_ldi();
        logic [4:0] op;
        int pulses;
        ir_a = 32'h40880000; op = ir_a[31:27]; pulses = 0;
        clr_a = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            pulses += int'(done_a);
            total++;
            if (obs_a !== exp_vec(op, 0, k)) begin bad++; $display("FAIL ldi k=%0d got=%h exp=%h", k, obs_a, exp_vec(op, 0, k)); end
        end
        total++; if (cnt_a !== 16'd0) begin bad++; $display("FAIL ldi_count_before got=%0d exp=0", cnt_a); end
        @(negedge clk);
        exp_cnt_a = 1;
        total++; if (cnt_a !== 16'(exp_cnt_a)) begin bad++; $display("FAIL ldi_count got=%0d exp=%0d", cnt_a, exp_cnt_a); end
        total++; if (pulses != 1) begin bad++; $display("FAIL ldi_done_pulses got=%0d exp=1", pulses); end
        total++; if (obs_a !== exp_vec(op, 0, 0)) begin bad++; $display("FAIL ldi_next_t0 got=%h exp=%h", obs_a, exp_vec(op, 0, 0)); end
    endtask

    task automatic test_jal_jr_mul();
        logic [4:0] ops [3] = '{5'd19, 5'd20, 5'd15};
        for (int i = 0; i < 3; i++) begin
            ir_a = {ops[i], 27'($urandom)};
            for (int k = 0; k < ilen(ops[i], 0); k++) begin
                if (k > 0) @(negedge clk);
                total++;
                if (obs_a !== exp_vec(ops[i], 0, k)) begin bad++; $display("FAIL jal_jr_mul op=%0d k=%0d got=%h exp=%h", ops[i], k, obs_a, exp_vec(ops[i], 0, k)); end
            end
            @(negedge clk);
            exp_cnt_a++;
            total++; if (cnt_a !== 16'(exp_cnt_a)) begin bad++; $display("FAIL jal_jr_mul_count got=%0d exp=%0d", cnt_a, exp_cnt_a); end
        end
    endtask

    task automatic test_random_a();
        logic [4:0] op;
        for (int i = 0; i < 25; i++) begin
            op = rand_op();
            ir_a = {op, 27'($urandom)};
            for (int k = 0; k < ilen(op, 0); k++) begin
                if (k > 0) @(negedge clk);
                total++;
                if (obs_a !== exp_vec(op, 0, k)) begin bad++; $display("FAIL random_a op=%0d k=%0d got=%h exp=%h", op, k, obs_a, exp_vec(op, 0, k)); end
            end
            @(negedge clk);
            exp_cnt_a++;
            total++; if (cnt_a !== 16'(exp_cnt_a)) begin bad++; $display("FAIL random_a_count got=%0d exp=%0d", cnt_a, exp_cnt_a); end
        end
    endtask

    task automatic test_illegal_halt();
        logic [4:0] ops [2] = '{5'd31, 5'd27};
        clr_a = 1'b1; @(negedge clk); clr_a = 1'b0; exp_cnt_a = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            ir_a = {ops[i], 27'($urandom)};
            for (int k = 0; k < ilen(ops[i], 0); k++) begin
                if (k > 0) @(negedge clk);
                total++;
                if (obs_a !== exp_vec(ops[i], 0, k)) begin bad++; $display("FAIL illegal_halt op=%0d k=%0d got=%h exp=%h", ops[i], k, obs_a, exp_vec(ops[i], 0, k)); end
            end
            @(negedge clk);
            exp_cnt_a++;
        end
        for (int c = 0; c < 20; c++) begin
            total++; if (obs_a !== HALTED) begin bad++; $display("FAIL halt_hold c=%0d got=%h exp=%h", c, obs_a, HALTED); end
            total++; if (cnt_a !== 16'(exp_cnt_a)) begin bad++; $display("FAIL halt_count got=%0d exp=%0d", cnt_a, exp_cnt_a); end
            @(negedge clk);
        end
    endtask

    task automatic test_stop_clr();
        logic [4:0] op;
        op = 5'd4;
        ir_a = {op, 27'($urandom)};
        clr_a = 1'b1; @(negedge clk); clr_a = 1'b0; exp_cnt_a = 0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            total++;
            if (obs_a !== exp_vec(op, 0, k)) begin bad++; $display("FAIL stop_instr k=%0d got=%h exp=%h", k, obs_a, exp_vec(op, 0, k)); end
            if (k == 1) stop_a = 1'b1;
        end
        @(negedge clk);
        exp_cnt_a = 1;
        total++; if (obs_a !== 28'd0) begin bad++; $display("FAIL stop_idle got=%h exp=0", obs_a); end
        total++; if (cnt_a !== 16'(exp_cnt_a)) begin bad++; $display("FAIL stop_count got=%0d exp=%0d", cnt_a, exp_cnt_a); end
        @(negedge clk);
        total++; if (obs_a !== 28'd0) begin bad++; $display("FAIL stop_idle_hold got=%h exp=0", obs_a); end
        stop_a = 1'b0;
        @(negedge clk);
        total++; if (obs_a !== exp_vec(op, 0, 0)) begin bad++; $display("FAIL idle_exit got=%h exp=%h", obs_a, exp_vec(op, 0, 0)); end
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (obs_a !== exp_vec(op, 0, k)) begin bad++; $display("FAIL restart k=%0d got=%h exp=%h", k, obs_a, exp_vec(op, 0, k)); end
        end
        #2 clr_a = 1'b1;
        #1;
        total++; if (obs_a !== 28'd0) begin bad++; $display("FAIL async_clr_strobes got=%h exp=0", obs_a); end
        total++; if (cnt_a !== 16'd0) begin bad++; $display("FAIL async_clr_count got=%0d exp=0", cnt_a); end
    endtask

    task automatic test_wait_wrap();
        logic [4:0] op;
        int reads;
        op = 5'd3; reads = 0;
        ir_b = {op, 27'($urandom)};
        @(negedge clk);
        clr_b = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            reads += int'(obs_b[10]);
            total++;
            if (obs_b !== exp_vec(op, 2, k)) begin bad++; $display("FAIL wait_add k=%0d got=%h exp=%h", k, obs_b, exp_vec(op, 2, k)); end
        end
        total++; if (reads != 3) begin bad++; $display("FAIL wait_read_cycles got=%0d exp=3", reads); end
        @(negedge clk);
        exp_cnt_b = 1;
        total++; if (cnt_b !== 3'(exp_cnt_b)) begin bad++; $display("FAIL wait_count got=%0d exp=%0d", cnt_b, exp_cnt_b); end
        for (int i = 0; i < 12; i++) begin
            op = rand_op();
            ir_b = {op, 27'($urandom)};
            for (int k = 0; k < ilen(op, 2); k++) begin
                if (k > 0) @(negedge clk);
                total++;
                if (obs_b !== exp_vec(op, 2, k)) begin bad++; $display("FAIL random_b op=%0d k=%0d got=%h exp=%h", op, k, obs_b, exp_vec(op, 2, k)); end
            end
            @(negedge clk);
            exp_cnt_b = (exp_cnt_b + 1) % 8;
            total++; if (cnt_b !== 3'(exp_cnt_b)) begin bad++; $display("FAIL wrap_count got=%0d exp=%0d", cnt_b, exp_cnt_b); end
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_jal_jr_mul();
        test_random_a();
        test_illegal_halt();
        test_stop_clr();
        test_wait_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
